hazard_unit_param: RTL and testbench
====================================

Name: hazard_unit_param

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage RV32 core.
- Sits beside ID. Detects RAW hazards against EX/MEM/WB and drives forwarding muxes.
- Adds sequential behaviour:
  - an N-cycle load-use stall FSM;
  - a multi-cycle EX unit (mul/div) hold;
  - a no-forwarding mode;
  - saturating stall/flush performance counters.

Parameters:
- XLEN, 32, data width of forwarded values.
- RAW, 5, register-address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard. Legal values are 1 or 2; 2 models late load data taken from WB.
- FWD_EN, 1, forwarding enable. 1 = forward; 0 = stall until the producer leaves WB.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rD1_used / rD2_used  in  1  ID instruction reads rs1 / rs2
- rR1_ID / rR2_ID  in  RAW  source register numbers in ID
- rf_we_EX / rf_we_MEM / rf_we_WB  in  1  stage writes RF
- wR_EX / wR_MEM / wR_WB  in  RAW  stage destination register
- wD_EX / wD_MEM / wD_WB  in  XLEN  stage result
- is_load_EX  in  1  EX holds a load
- npc_op  in  1  branch/jump taken, resolved in EX
- md_busy  in  1  multi-cycle EX unit not done
- cnt_clr  in  1  synchronous clear of the perf counters
- keep_PC / keep_IF_ID / keep_ID_EX  out  1  hold register
- flush_IF_ID / flush_ID_EX / flush_EX_MEM  out  1  insert bubble
- rD1_op / rD2_op  out  1  forward select
- rD1_forward / rD2_forward  out  XLEN  forwarded data
- stall_cnt  out  CNT_W  cycles with keep_PC=1
- flush_cnt  out  CNT_W  control flushes taken

Behaviour:
- Reset: clk is the only clock; rst_n is an asynchronous, active-low reset.
  - rst_n=0 sets state=IDLE, lcnt=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, all keep_*/flush_* outputs are 0.
- RAW match per stage S∈{EX,MEM,WB}, per source k: hit_S_k = rf_we_S && rDk_used && wR_S!=0 && wR_S==rRk_ID.
- Forwarding when FWD_EN=1:
  - rDk_op = hit_EX_k | hit_MEM_k | hit_WB_k.
  - Data priority is EX > MEM > WB; data is 0 when there is no hit. This path is combinational.
- Forwarding when FWD_EN=0:
  - rDk_op=0 and rDk_forward=0.
  - Any hit on any stage gives a data stall: keep_PC=keep_IF_ID=1, flush_ID_EX=1. This is combinational, is evaluated only in IDLE, and repeats each cycle until no hit remains.
- FSM states are IDLE, LSTALL and MDWAIT. Priority each cycle: npc_op > md_busy > load-use > data stall.
- npc_op=1 (any state):
  - flush_IF_ID=1 and flush_ID_EX=1.
  - Next state is IDLE and lcnt is cleared.
  - flush_cnt increments.
  - An npc_op that coincides with md_busy=1 is ignored, because the branch is not in EX while MD is busy.
- md_busy=1, from IDLE or LSTALL:
  - keep_PC=keep_IF_ID=keep_ID_EX=1, flush_EX_MEM=1.
  - State becomes MDWAIT. While in MDWAIT with md_busy=0, return to IDLE and release the holds in that same cycle.
  - An LSTALL that is preempted is discarded.
- Load-use, in IDLE, FWD_EN=1:
  - Condition: is_load_EX && (hit_EX_1|hit_EX_2).
  - Outputs this cycle: keep_PC=keep_IF_ID=1, flush_ID_EX=1.
  - If LOAD_STALL=1, stay in IDLE. If LOAD_STALL=2, go to LSTALL with lcnt=1.
- LSTALL:
  - Same outputs as load-use (keep_PC=keep_IF_ID=1, flush_ID_EX=1); lcnt decrements.
  - At lcnt==0, go to IDLE. Total bubbles = LOAD_STALL.
- Counters:
  - stall_cnt += 1 on each cycle with keep_PC=1; flush_cnt as above.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - cnt_clr=1 zeroes both next cycle and overrides a simultaneous increment.
- Register x0 is never a hazard.

Test Plan:
- Back-to-back ALU, FWD_EN=1: EX writes x5=0x11, ID reads rs1=x5. Expect rD1_op=1, rD1_forward=0x11, no keep. Add MEM x5=0x22: still 0x11, since EX has priority.
- Load-use with LOAD_STALL=2: is_load_EX, wR_EX=x7, ID rs2=x7. Expect keep_PC high for exactly 2 cycles, flush_ID_EX 2 cycles, stall_cnt=2, then forwarding from WB.
- npc_op during LSTALL second cycle: expect flush_IF_ID=flush_ID_EX=1, FSM back to IDLE, keep_PC=0 next cycle, flush_cnt=1.
- md_busy held 5 cycles: expect keep_PC/IF_ID/ID_EX=1 and flush_EX_MEM=1 for 5 cycles, released the cycle md_busy falls, stall_cnt=5.
- FWD_EN=0: EX writes x3, ID reads x3. Expect a 3-cycle stall while the producer sits in EX→MEM→WB, with rD1_op=0 throughout. Repeat with wR=x0: expect no stall.
- Reset and saturation, CNT_W=4:
  - Hold stall 20 cycles: stall_cnt sticks at 15. Pulse cnt_clr: 0.
  - Drop rst_n mid-LSTALL: outputs go 0 immediately and the FSM is in IDLE after release.

Source files
------------

// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit for the 5-stage RV32 core: RAW detection, forwarding, load-use,
// multi-cycle EX hold, branch flush and saturating stall/flush performance counters.
module hazard_unit_param #(
    parameter int XLEN       = 32,
    parameter int RAW        = 5,
    parameter int LOAD_STALL = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rD1_used,
    input  logic             rD2_used,
    input  logic [RAW-1:0]   rR1_ID,
    input  logic [RAW-1:0]   rR2_ID,
    input  logic             rf_we_EX,
    input  logic             rf_we_MEM,
    input  logic             rf_we_WB,
    input  logic [RAW-1:0]   wR_EX,
    input  logic [RAW-1:0]   wR_MEM,
    input  logic [RAW-1:0]   wR_WB,
    input  logic [XLEN-1:0]  wD_EX,
    input  logic [XLEN-1:0]  wD_MEM,
    input  logic [XLEN-1:0]  wD_WB,
    input  logic             is_load_EX,
    input  logic             npc_op,
    input  logic             md_busy,
    input  logic             cnt_clr,
    output logic             keep_PC,
    output logic             keep_IF_ID,
    output logic             keep_ID_EX,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             rD1_op,
    output logic             rD2_op,
    output logic [XLEN-1:0]  rD1_forward,
    output logic [XLEN-1:0]  rD2_forward,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {IDLE, LSTALL, MDWAIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         lcnt_q, lcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic hit_ex_1, hit_mem_1, hit_wb_1;
    logic hit_ex_2, hit_mem_2, hit_wb_2;
    logic any_hit, branch;
    logic keep_pc_c, keep_if_id_c, keep_id_ex_c;
    logic flush_if_id_c, flush_id_ex_c, flush_ex_mem_c;

    // x0 is hard-wired to zero, so a write to it never creates a dependency
    assign hit_ex_1  = rf_we_EX  && rD1_used && (wR_EX  != '0) && (wR_EX  == rR1_ID);
    assign hit_mem_1 = rf_we_MEM && rD1_used && (wR_MEM != '0) && (wR_MEM == rR1_ID);
    assign hit_wb_1  = rf_we_WB  && rD1_used && (wR_WB  != '0) && (wR_WB  == rR1_ID);
    assign hit_ex_2  = rf_we_EX  && rD2_used && (wR_EX  != '0) && (wR_EX  == rR2_ID);
    assign hit_mem_2 = rf_we_MEM && rD2_used && (wR_MEM != '0) && (wR_MEM == rR2_ID);
    assign hit_wb_2  = rf_we_WB  && rD2_used && (wR_WB  != '0) && (wR_WB  == rR2_ID);

    assign any_hit = hit_ex_1 | hit_mem_1 | hit_wb_1 | hit_ex_2 | hit_mem_2 | hit_wb_2;
    // While MD is busy the branch cannot be in EX, so npc_op is meaningless then
    assign branch  = npc_op && !md_busy;

    always_comb begin
        rD1_op      = 1'b0;
        rD2_op      = 1'b0;
        rD1_forward = '0;
        rD2_forward = '0;
        if (FWD_EN != 0) begin
            rD1_op = hit_ex_1 | hit_mem_1 | hit_wb_1;
            rD2_op = hit_ex_2 | hit_mem_2 | hit_wb_2;
            if (hit_ex_1)       rD1_forward = wD_EX;
            else if (hit_mem_1) rD1_forward = wD_MEM;
            else if (hit_wb_1)  rD1_forward = wD_WB;
            if (hit_ex_2)       rD2_forward = wD_EX;
            else if (hit_mem_2) rD2_forward = wD_MEM;
            else if (hit_wb_2)  rD2_forward = wD_WB;
        end
    end

    always_comb begin
        state_d        = state_q;
        lcnt_d         = lcnt_q;
        keep_pc_c      = 1'b0;
        keep_if_id_c   = 1'b0;
        keep_id_ex_c   = 1'b0;
        flush_if_id_c  = 1'b0;
        flush_id_ex_c  = 1'b0;
        flush_ex_mem_c = 1'b0;
        if (branch) begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            state_d       = IDLE;
            lcnt_d        = '0;
        end else if (md_busy) begin
            keep_pc_c      = 1'b1;
            keep_if_id_c   = 1'b1;
            keep_id_ex_c   = 1'b1;
            flush_ex_mem_c = 1'b1;
            state_d        = MDWAIT;
            lcnt_d         = '0;
        end else if (state_q == LSTALL) begin
            keep_pc_c     = 1'b1;
            keep_if_id_c  = 1'b1;
            flush_id_ex_c = 1'b1;
            lcnt_d        = lcnt_q - 2'd1;
            if (lcnt_q <= 2'd1) begin
                state_d = IDLE;
            end
        end else begin
            // MDWAIT with md_busy low releases immediately and behaves as IDLE
            state_d = IDLE;
            if ((FWD_EN != 0) && is_load_EX && (hit_ex_1 || hit_ex_2)) begin
                keep_pc_c     = 1'b1;
                keep_if_id_c  = 1'b1;
                flush_id_ex_c = 1'b1;
                if (LOAD_STALL > 1) begin
                    state_d = LSTALL;
                    lcnt_d  = 2'(LOAD_STALL - 1);
                end
            end else if ((FWD_EN == 0) && any_hit) begin
                keep_pc_c     = 1'b1;
                keep_if_id_c  = 1'b1;
                flush_id_ex_c = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (keep_pc_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (branch && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Control outputs are forced low for the whole time reset is asserted
    assign keep_PC      = rst_n & keep_pc_c;
    assign keep_IF_ID   = rst_n & keep_if_id_c;
    assign keep_ID_EX   = rst_n & keep_id_ex_c;
    assign flush_IF_ID  = rst_n & flush_if_id_c;
    assign flush_ID_EX  = rst_n & flush_id_ex_c;
    assign flush_EX_MEM = rst_n & flush_ex_mem_c;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// Scoreboard bench for hazard_unit_param: three instances (LOAD_STALL=2, no-forwarding,
// 4-bit counters) share one stimulus stream; expectations are queued and drained each cycle.
module tb_hazard_unit_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rD1_used, rD2_used;
    logic [4:0]  rR1_ID, rR2_ID;
    logic        rf_we_EX, rf_we_MEM, rf_we_WB;
    logic [4:0]  wR_EX, wR_MEM, wR_WB;
    logic [31:0] wD_EX, wD_MEM, wD_WB;
    logic        is_load_EX, npc_op, md_busy, cnt_clr;

    logic [7:0]  a_ctrl, b_ctrl, c_ctrl;
    logic [31:0] a_fwd1, a_fwd2, b_fwd1, b_fwd2, c_fwd1, c_fwd2;
    logic [15:0] a_stall, a_flush, b_stall, b_flush;
    logic [3:0]  c_stall, c_flush;

    always #5 clk = ~clk;

    // ctrl bit order: keep_PC keep_IF_ID keep_ID_EX flush_IF_ID flush_ID_EX flush_EX_MEM rD1_op rD2_op
    hazard_unit_param #(.XLEN(32), .RAW(5), .LOAD_STALL(2), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .rD1_used(rD1_used), .rD2_used(rD2_used),
        .rR1_ID(rR1_ID), .rR2_ID(rR2_ID), .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM),
        .rf_we_WB(rf_we_WB), .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
        .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB), .is_load_EX(is_load_EX),
        .npc_op(npc_op), .md_busy(md_busy), .cnt_clr(cnt_clr),
        .keep_PC(a_ctrl[7]), .keep_IF_ID(a_ctrl[6]), .keep_ID_EX(a_ctrl[5]),
        .flush_IF_ID(a_ctrl[4]), .flush_ID_EX(a_ctrl[3]), .flush_EX_MEM(a_ctrl[2]),
        .rD1_op(a_ctrl[1]), .rD2_op(a_ctrl[0]), .rD1_forward(a_fwd1), .rD2_forward(a_fwd2),
        .stall_cnt(a_stall), .flush_cnt(a_flush));

    hazard_unit_param #(.XLEN(32), .RAW(5), .LOAD_STALL(1), .FWD_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rD1_used(rD1_used), .rD2_used(rD2_used),
        .rR1_ID(rR1_ID), .rR2_ID(rR2_ID), .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM),
        .rf_we_WB(rf_we_WB), .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
        .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB), .is_load_EX(is_load_EX),
        .npc_op(npc_op), .md_busy(md_busy), .cnt_clr(cnt_clr),
        .keep_PC(b_ctrl[7]), .keep_IF_ID(b_ctrl[6]), .keep_ID_EX(b_ctrl[5]),
        .flush_IF_ID(b_ctrl[4]), .flush_ID_EX(b_ctrl[3]), .flush_EX_MEM(b_ctrl[2]),
        .rD1_op(b_ctrl[1]), .rD2_op(b_ctrl[0]), .rD1_forward(b_fwd1), .rD2_forward(b_fwd2),
        .stall_cnt(b_stall), .flush_cnt(b_flush));

    hazard_unit_param #(.XLEN(32), .RAW(5), .LOAD_STALL(2), .FWD_EN(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .rD1_used(rD1_used), .rD2_used(rD2_used),
        .rR1_ID(rR1_ID), .rR2_ID(rR2_ID), .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM),
        .rf_we_WB(rf_we_WB), .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
        .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB), .is_load_EX(is_load_EX),
        .npc_op(npc_op), .md_busy(md_busy), .cnt_clr(cnt_clr),
        .keep_PC(c_ctrl[7]), .keep_IF_ID(c_ctrl[6]), .keep_ID_EX(c_ctrl[5]),
        .flush_IF_ID(c_ctrl[4]), .flush_ID_EX(c_ctrl[3]), .flush_EX_MEM(c_ctrl[2]),
        .rD1_op(c_ctrl[1]), .rD2_op(c_ctrl[0]), .rD1_forward(c_fwd1), .rD2_forward(c_fwd2),
        .stall_cnt(c_stall), .flush_cnt(c_flush));

    localparam logic [8:0] WE_EX = 9'h100, WE_MEM = 9'h080, WE_WB = 9'h040, U1 = 9'h020,
                           U2 = 9'h010, LD = 9'h008, NPC = 9'h004, MD = 9'h002, CLR = 9'h001;
    localparam int A_CTRL = 0, A_FWD1 = 1, A_FWD2 = 2, A_STALL = 3, A_FLUSH = 4, B_CTRL = 5,
                   B_FWD1 = 6, B_STALL = 7, C_CTRL = 8, C_STALL = 9, C_FLUSH = 10;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            A_CTRL:  return 32'(a_ctrl);
            A_FWD1:  return a_fwd1;
            A_FWD2:  return a_fwd2;
            A_STALL: return 32'(a_stall);
            A_FLUSH: return 32'(a_flush);
            B_CTRL:  return 32'(b_ctrl);
            B_FWD1:  return b_fwd1;
            B_STALL: return 32'(b_stall);
            C_CTRL:  return 32'(c_ctrl);
            C_STALL: return 32'(c_stall);
            C_FLUSH: return 32'(c_flush);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [8:0] ctl, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] w_ex, input logic [31:0] d_ex,
                                 input logic [4:0] w_mem, input logic [31:0] d_mem,
                                 input logic [4:0] w_wb, input logic [31:0] d_wb);
        rf_we_EX   = ctl[8];
        rf_we_MEM  = ctl[7];
        rf_we_WB   = ctl[6];
        rD1_used   = ctl[5];
        rD2_used   = ctl[4];
        is_load_EX = ctl[3];
        npc_op     = ctl[2];
        md_busy    = ctl[1];
        cnt_clr    = ctl[0];
        rR1_ID     = r1;
        rR2_ID     = r2;
        wR_EX      = w_ex;
        wD_EX      = d_ex;
        wR_MEM     = w_mem;
        wD_MEM     = d_mem;
        wR_WB      = w_wb;
        wD_WB      = d_wb;
    endtask

    task automatic idle(input logic [8:0] ctl);
        applyStimulus(ctl, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    endtask

    // Drain the scoreboard mid-cycle, then advance to just after the next rising edge
    task automatic runCycle();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(WE_EX | U1, 5'd3, 5'd0, 5'd3, 32'h99, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("rst_ctrl_gated", B_CTRL, 8'h00);
        pushExp("rst_fwd_op", A_CTRL, 8'h02);
        pushExp("rst_stall_cnt", A_STALL, 0);
        pushExp("rst_flush_cnt", A_FLUSH, 0);
        runCycle();
        runCycle();
        rst_n = 1'b1;

        $display("[TB] forwarding priority");
        applyStimulus(WE_EX | U1, 5'd5, 5'd0, 5'd5, 32'h11, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("fwd_ex_ctrl", A_CTRL, 8'h02);
        pushExp("fwd_ex_data", A_FWD1, 32'h11);
        runCycle();
        applyStimulus(WE_EX | WE_MEM | U1, 5'd5, 5'd0, 5'd5, 32'h11, 5'd5, 32'h22, 5'd0, 32'h0);
        pushExp("fwd_prio_ctrl", A_CTRL, 8'h02);
        pushExp("fwd_prio_ex", A_FWD1, 32'h11);
        runCycle();
        applyStimulus(WE_MEM | WE_WB | U1, 5'd5, 5'd0, 5'd0, 32'h0, 5'd5, 32'h22, 5'd5, 32'h33);
        pushExp("fwd_prio_mem", A_FWD1, 32'h22);
        runCycle();
        applyStimulus(WE_WB | U2, 5'd0, 5'd5, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h33);
        pushExp("fwd_wb_ctrl", A_CTRL, 8'h01);
        pushExp("fwd_wb_data", A_FWD2, 32'h33);
        runCycle();
        applyStimulus(WE_EX | U2, 5'd5, 5'd5, 5'd5, 32'h44, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("fwd_unused_ctrl", A_CTRL, 8'h01);
        pushExp("fwd_unused_data", A_FWD1, 32'h0);
        runCycle();
        applyStimulus(WE_EX | U1, 5'd0, 5'd0, 5'd0, 32'h55, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("fwd_x0_ctrl", A_CTRL, 8'h00);
        pushExp("fwd_x0_data", A_FWD1, 32'h0);
        runCycle();
        applyStimulus(U1, 5'd5, 5'd0, 5'd5, 32'h66, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("fwd_no_we_ctrl", A_CTRL, 8'h00);
        runCycle();

        $display("[TB] load-use with two bubbles");
        idle(CLR);
        runCycle();
        applyStimulus(WE_EX | LD | U2, 5'd0, 5'd7, 5'd7, 32'hdead, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("lu_t0_ctrl", A_CTRL, 8'hC9);
        pushExp("lu_t0_stall", A_STALL, 0);
        runCycle();
        applyStimulus(WE_MEM | U2, 5'd0, 5'd7, 5'd0, 32'h0, 5'd7, 32'hAA, 5'd0, 32'h0);
        pushExp("lu_t1_ctrl", A_CTRL, 8'hC9);
        pushExp("lu_t1_fwd", A_FWD2, 32'hAA);
        pushExp("lu_t1_stall", A_STALL, 1);
        runCycle();
        applyStimulus(WE_WB | U2, 5'd0, 5'd7, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h77);
        pushExp("lu_t2_ctrl", A_CTRL, 8'h01);
        pushExp("lu_t2_fwd_wb", A_FWD2, 32'h77);
        pushExp("lu_t2_stall", A_STALL, 2);
        runCycle();

        $display("[TB] branch during load stall");
        idle(9'h0);
        runCycle();
        applyStimulus(WE_EX | LD | U2, 5'd0, 5'd7, 5'd7, 32'hdead, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("br_t0_ctrl", A_CTRL, 8'hC9);
        runCycle();
        applyStimulus(WE_MEM | U2 | NPC, 5'd0, 5'd7, 5'd0, 32'h0, 5'd7, 32'hAA, 5'd0, 32'h0);
        pushExp("br_t1_ctrl", A_CTRL, 8'h19);
        pushExp("br_t1_flush", A_FLUSH, 0);
        runCycle();
        idle(9'h0);
        pushExp("br_t2_ctrl", A_CTRL, 8'h00);
        pushExp("br_t2_flush", A_FLUSH, 1);
        pushExp("br_t2_stall", A_STALL, 3);
        runCycle();

        $display("[TB] multi-cycle EX hold");
        idle(CLR);
        runCycle();
        for (int i = 0; i < 5; i++) begin
            idle(MD | ((i == 2) ? NPC : 9'h0));
            pushExp("md_ctrl", A_CTRL, 8'hE4);
            pushExp("md_stall", A_STALL, i);
            runCycle();
        end
        idle(9'h0);
        pushExp("md_release_ctrl", A_CTRL, 8'h00);
        pushExp("md_release_stall", A_STALL, 5);
        pushExp("md_npc_ignored", A_FLUSH, 0);
        runCycle();

        $display("[TB] no-forwarding data stall");
        idle(CLR);
        runCycle();
        applyStimulus(WE_EX | U1, 5'd3, 5'd0, 5'd3, 32'h31, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("nf_t0_ctrl", B_CTRL, 8'hC8);
        pushExp("nf_t0_fwd", B_FWD1, 32'h0);
        pushExp("nf_t0_stall", B_STALL, 0);
        runCycle();
        applyStimulus(WE_MEM | U1, 5'd3, 5'd0, 5'd0, 32'h0, 5'd3, 32'h31, 5'd0, 32'h0);
        pushExp("nf_t1_ctrl", B_CTRL, 8'hC8);
        runCycle();
        applyStimulus(WE_WB | U1, 5'd3, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'h31);
        pushExp("nf_t2_ctrl", B_CTRL, 8'hC8);
        runCycle();
        applyStimulus(U1, 5'd3, 5'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("nf_t3_ctrl", B_CTRL, 8'h00);
        pushExp("nf_t3_stall", B_STALL, 3);
        runCycle();
        applyStimulus(WE_EX | WE_MEM | WE_WB | U1, 5'd0, 5'd0, 5'd0, 32'h1, 5'd0, 32'h2, 5'd0, 32'h3);
        pushExp("nf_x0_ctrl", B_CTRL, 8'h00);
        runCycle();
        idle(9'h0);
        pushExp("nf_x0_stall", B_STALL, 3);
        runCycle();

        $display("[TB] counter saturation");
        idle(CLR);
        runCycle();
        for (int i = 0; i < 20; i++) begin
            idle(MD);
            pushExp("sat_stall", C_STALL, (i > 15) ? 15 : i);
            runCycle();
        end
        idle(MD | CLR);
        pushExp("sat_clr_ctrl", C_CTRL, 8'hE4);
        pushExp("sat_clr_hold", C_STALL, 15);
        runCycle();
        idle(9'h0);
        pushExp("sat_cleared", C_STALL, 0);
        pushExp("sat_release", C_CTRL, 8'h00);
        runCycle();
        for (int i = 0; i < 17; i++) begin
            idle(NPC);
            pushExp("sat_flush_ctrl", C_CTRL, 8'h18);
            pushExp("sat_flush", C_FLUSH, (i > 15) ? 15 : i);
            runCycle();
        end
        idle(9'h0);
        pushExp("sat_flush_end", C_FLUSH, 15);
        pushExp("sat_flush_nostall", C_STALL, 0);
        runCycle();

        $display("[TB] reset during load stall");
        applyStimulus(WE_EX | LD | U2, 5'd0, 5'd7, 5'd7, 32'hbeef, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("rl_t0_ctrl", C_CTRL, 8'hC9);
        runCycle();
        applyStimulus(WE_EX | LD | U2, 5'd0, 5'd7, 5'd7, 32'hbeef, 5'd0, 32'h0, 5'd0, 32'h0);
        rst_n = 1'b0;
        pushExp("rl_a_ctrl", A_CTRL, 8'h01);
        pushExp("rl_c_ctrl", C_CTRL, 8'h01);
        pushExp("rl_a_stall", A_STALL, 0);
        pushExp("rl_c_stall", C_STALL, 0);
        pushExp("rl_c_flush", C_FLUSH, 0);
        runCycle();
        rst_n = 1'b1;
        idle(9'h0);
        pushExp("rl_a_idle", A_CTRL, 8'h00);
        pushExp("rl_c_idle", C_CTRL, 8'h00);
        runCycle();
        applyStimulus(WE_EX | LD | U2, 5'd0, 5'd7, 5'd7, 32'hbeef, 5'd0, 32'h0, 5'd0, 32'h0);
        pushExp("rl_c_relu", C_CTRL, 8'hC9);
        runCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
